magnitude_comparator: RTL and testbench

Parameterised N-bit magnitude comparator with registered outputs. It compares two operands and reports exactly one of equal, less-than or greater-than one clock after a valid input is presented. It serves as a standalone compare stage for datapath blocks that need a timing-clean, one-hot relation flag.

---
 rtl/magnitude_comparator.sv | 61 ++++++
 tb/tb_magnitude_comparator.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/magnitude_comparator.sv
// N-bit magnitude comparator with one-cycle registered, one-hot eq/lt/gt flags.
// Define MAG_CMP_SIGNED_EN to compare operands as two's-complement signed values.
module magnitude_comparator #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out_valid,
  output logic         eq,
  output logic         lt,
  output logic         gt
);

  logic eq_s;
  logic lt_s;
  logic gt_s;
  logic out_valid_r;
  logic eq_r;
  logic lt_r;
  logic gt_r;

  // Combinational relation of the current operand pair.
  always_comb begin
    eq_s = 1'b0;
    lt_s = 1'b0;
    gt_s = 1'b0;
    eq_s = (a == b);
`ifdef MAG_CMP_SIGNED_EN
    lt_s = ($signed(a) < $signed(b));
`else
    lt_s = (a < b);
`endif
    gt_s = ~eq_s & ~lt_s;
  end

  // Result registers; flags hold their value across idle cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      eq_r        <= 1'b0;
      lt_r        <= 1'b0;
      gt_r        <= 1'b0;
    end else if (in_valid) begin
      out_valid_r <= 1'b1;
      eq_r        <= eq_s;
      lt_r        <= lt_s;
      gt_r        <= gt_s;
    end else begin
      out_valid_r <= 1'b0;
    end
  end

  assign out_valid = out_valid_r;
  assign eq        = eq_r;
  assign lt        = lt_r;
  assign gt        = gt_r;

endmodule

// File: tb/tb_magnitude_comparator.sv
// Scoreboard bench for magnitude_comparator: a 16-bit instance and a 4-bit
// instance share the clock, reset and valid, and are checked one cycle after drive.
module tb_magnitude_comparator;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [15:0] a16;
  logic [15:0] b16;
  logic [3:0]  a4;
  logic [3:0]  b4;
  logic        ov16, eq16, lt16, gt16;
  logic        ov4, eq4, lt4, gt4;

  int total = 0;
  int bad   = 0;

  logic [3:0] q16[$];
  logic [3:0] q4[$];
  string      qtag[$];
  logic [2:0] m16_r;
  logic [2:0] m4_r;

  always #5 clk = ~clk;

  magnitude_comparator #(.N(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a16), .b(b16),
    .out_valid(ov16), .eq(eq16), .lt(lt16), .gt(gt16)
  );

  magnitude_comparator #(.N(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a4), .b(b4),
    .out_valid(ov4), .eq(eq4), .lt(lt4), .gt(gt4)
  );

  task automatic check_value(input string tag, input logic [3:0] got, input logic [3:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b ({valid,eq,lt,gt})", tag, got, exp);
    end
  endtask

  // Reference relation: flipping the sign bit maps signed order onto unsigned order.
  function automatic logic [2:0] rel16(input logic [15:0] x, input logic [15:0] y);
    logic [15:0] xs;
    logic [15:0] ys;
    xs = x;
    ys = y;
`ifdef MAG_CMP_SIGNED_EN
    xs[15] = ~x[15];
    ys[15] = ~y[15];
`endif
    if (xs == ys) return 3'b100;
    else if (xs < ys) return 3'b010;
    else return 3'b001;
  endfunction

  function automatic logic [2:0] rel4(input logic [3:0] x, input logic [3:0] y);
    logic [3:0] xs;
    logic [3:0] ys;
    xs = x;
    ys = y;
`ifdef MAG_CMP_SIGNED_EN
    xs[3] = ~x[3];
    ys[3] = ~y[3];
`endif
    if (xs == ys) return 3'b100;
    else if (xs < ys) return 3'b010;
    else return 3'b001;
  endfunction

  task automatic check_zero(input string tag);
    check_value({tag, "/16"}, {ov16, eq16, lt16, gt16}, 4'b0000);
    check_value({tag, "/4"},  {ov4,  eq4,  lt4,  gt4},  4'b0000);
  endtask

  // One cycle: compare the previous cycle's expectation, then drive and predict.
  task automatic step(input logic v, input logic [15:0] xa, input logic [15:0] xb,
                      input logic [3:0] ya, input logic [3:0] yb, input string tag);
    logic [3:0] e16;
    logic [3:0] e4;
    string      t;
    @(negedge clk);
    if (q16.size() > 0) begin
      e16 = q16.pop_front();
      e4  = q4.pop_front();
      t   = qtag.pop_front();
      check_value({t, "/16"}, {ov16, eq16, lt16, gt16}, e16);
      check_value({t, "/4"},  {ov4,  eq4,  lt4,  gt4},  e4);
      if (e4[3]) check_value({t, "/onehot4"}, {3'b000, ($countones({eq4, lt4, gt4}) == 1)}, 4'b0001);
    end
    in_valid = v;
    a16 = xa;
    b16 = xb;
    a4  = ya;
    b4  = yb;
    if (v) begin
      m16_r = rel16(xa, xb);
      m4_r  = rel4(ya, yb);
    end
    q16.push_back({v, m16_r});
    q4.push_back({v, m4_r});
    qtag.push_back(tag);
  endtask

  task automatic flush_model();
    q16.delete();
    q4.delete();
    qtag.delete();
    m16_r = 3'b000;
    m4_r  = 3'b000;
  endtask

  initial begin
    rst      = 1'b0;
    in_valid = 1'b1;
    a16 = 16'd5;
    b16 = 16'd3;
    a4  = 4'd5;
    b4  = 4'd3;
    m16_r = 3'b000;
    m4_r  = 3'b000;
    #1 rst = 1'b1;
    #1 check_zero("reset_async");
    @(negedge clk);
    check_zero("reset_edge1");
    @(negedge clk);
    check_zero("reset_edge2");
    rst = 1'b0;
    in_valid = 1'b0;
    flush_model();

    step(1'b1, 16'h1234, 16'h1234, 4'h4, 4'h4, "basic_eq");
    step(1'b1, 16'h0001, 16'h0002, 4'h1, 4'h2, "basic_lt");
    step(1'b1, 16'hFFFF, 16'h0000, 4'hF, 4'h0, "basic_gt");
    step(1'b0, 16'h0000, 16'h0009, 4'h0, 4'h9, "hold");
    step(1'b0, 16'h0000, 16'h0009, 4'h0, 4'h9, "hold2");
    step(1'b1, 16'h8000, 16'h0001, 4'h8, 4'h1, "sign_msb");
    step(1'b1, 16'hFFFF, 16'hFFFE, 4'hF, 4'hE, "sign_ones");
    step(1'b1, 16'h0000, 16'h0000, 4'h0, 4'h0, "zeros");

    for (int i = 0; i < 256; i++) begin
      logic [7:0] p;
      p = i[7:0];
      step(1'b1, {12'h000, p[7:4]}, {12'h000, p[3:0]}, p[7:4], p[3:0], $sformatf("exh_%0d", i));
    end
    step(1'b0, 16'h0000, 16'h0000, 4'h0, 4'h0, "drain");

    // Mid-stream reset, asserted between edges while a result is showing.
    step(1'b1, 16'h0007, 16'h0007, 4'h7, 4'h7, "pre_rst_eq");
    step(1'b1, 16'h0003, 16'h0009, 4'h3, 4'h9, "pre_rst_lt");
    @(posedge clk);
    #2;
    total++;
    if (ov16 !== 1'b1 || lt16 !== 1'b1) begin
      bad++;
      $display("FAIL pre_rst_visible: got ov=%b lt=%b expected 1 1", ov16, lt16);
    end
    in_valid = 1'b1;
    a16 = 16'h0002;
    b16 = 16'h0001;
    a4  = 4'h2;
    b4  = 4'h1;
    rst = 1'b1;
    #1 check_zero("midrst_async");
    flush_model();
    @(negedge clk);
    check_zero("midrst_edge");
    rst = 1'b0;
    in_valid = 1'b0;
    step(1'b0, 16'h0002, 16'h0001, 4'h2, 4'h1, "post_rst_idle");
    step(1'b1, 16'h0002, 16'h0001, 4'h2, 4'h1, "post_rst_gt");
    step(1'b0, 16'h0000, 16'h0000, 4'h0, 4'h0, "post_rst_hold");
    step(1'b0, 16'h0000, 16'h0000, 4'h0, 4'h0, "final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
